pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter TMO_W, default 8: width of the memory-wait timeout counter.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 clr  in  1  reset; synchronous, active-high.
REQ-005 d_valid  in  1  D stage holds a real instruction.
REQ-006 d_rs, d_rt  in  5 each  D-stage source register numbers.
REQ-007 d_use_rs, d_use_rt  in  1 each  the D instruction reads rs / rt.
REQ-008 ewreg, em2reg  in  1 each  E-stage register write; E-stage load.
REQ-009 ern  in  5  E-stage destination register.
REQ-010 mwreg, mm2reg  in  1 each  M-stage register write; M-stage load.
REQ-011 mrn  in  5  M-stage destination register.
REQ-012 e_jump  in  1  control transfer resolved taken in E.
REQ-013 mem_req, mem_ready  in  1 each  M-stage memory access active; memory done.
REQ-014 da_depen, db_depen  out  2 each  forwarding selects toward the D/E pipeline register.
REQ-015 wpcir  out  1  PC and F/D write enable; 0 = stall.
REQ-016 de_bubble  out  1  load a bubble (all-zero control) into D/E.
REQ-017 fd_flush  out  1  kill the F/D instruction.
REQ-018 pipe_hold  out  1  freeze the D/E, E/M and M/W registers.
REQ-019 mem_timeout  out  1  sticky memory-wait timeout flag.

Function
REQ-020 depen encoding SHALL be: 00 regfile, 01 E ALU result, 10 M ALU result, 11 M memory data.
REQ-021 For rs, da_depen SHALL be 01 if ewreg & !em2reg & ern!=0 & ern==d_rs; else 10 or 11 (by mm2reg) if mwreg & mrn!=0 & mrn==d_rs; else 00.
REQ-022 db_depen SHALL use the same rule as REQ-021 with d_rt; an E-stage match SHALL take priority over an M-stage match.
REQ-023 load_use SHALL be defined as d_valid & ewreg & em2reg & ern!=0 & ((d_use_rs & ern==d_rs) | (d_use_rt & ern==d_rt)).
REQ-024 The FSM SHALL have three states: RUN, LDSTALL and MEMWAIT, with a 2-bit encoding.
REQ-025 RUN, event priority: mem_req & !mem_ready first, then e_jump, then load_use.
REQ-026 RUN, mem_req & !mem_ready: next state MEMWAIT; pipe_hold=1, wpcir=0 in this cycle.
REQ-027 RUN, e_jump: fd_flush=1, de_bubble=1, wpcir=1; stay in RUN; a coincident load_use SHALL be ignored.
REQ-028 RUN, load_use only: wpcir=0, de_bubble=1; next state LDSTALL.
REQ-029 RUN, no event: wpcir=1 and all other control outputs 0.
REQ-030 LDSTALL SHALL behave exactly as RUN for the current cycle (including a fresh load_use) and SHALL exist for one cycle only, for statistics.
REQ-031 MEMWAIT: pipe_hold=1, wpcir=0; e_jump and load_use SHALL be ignored; the wait counter SHALL increment each cycle.
REQ-032 MEMWAIT exit: mem_ready=1 -> RUN with counter cleared; counter at all-ones -> set mem_timeout, RUN, counter cleared.
REQ-033 Outputs SHALL be combinational from state and inputs; latency of all hazard responses SHALL be zero cycles.
REQ-034 mem_timeout SHALL be cleared only by clr.

Reset
REQ-035 While clr=1 on posedge clk: state RUN, wait counter 0, mem_timeout 0, statistics counters 0.
REQ-036 Immediately after reset: wpcir=1; de_bubble, fd_flush and pipe_hold=0; depen values purely combinational.
REQ-037 clr asserted in MEMWAIT SHALL abort the wait with no timeout flag set.

Configuration
REQ-038 Macro PIPE_HAZARD_STATS_EN defined: add outputs stall_cnt and flush_cnt (CNT_W each).
REQ-039 stall_cnt SHALL count cycles with wpcir=0; flush_cnt SHALL count cycles with fd_flush=1.
REQ-040 Both counters SHALL saturate at all-ones and reset to 0.
REQ-041 Macro undefined: the ports and counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-042 A shared package SHALL hold the depen encodings (DEP_RF, DEP_EALU, DEP_MALU, DEP_MMEM) and the state encodings.
REQ-043 One sub-module, fwd_sel, SHALL compute a single depen value and be instantiated twice (rs, rt).

Verification
REQ-044 Load r5 in E; D reads rs=5 -> one cycle with wpcir=0, de_bubble=1; next cycle da_depen=11, state RUN.
REQ-045 ALU write r3 in E and r3 in M; D rt=3 -> db_depen=01.
REQ-046 ern=0 with ewreg=1; D rs=0 -> da_depen=00, no stall.
REQ-047 e_jump=1 with a coincident load_use -> fd_flush=1, de_bubble=1, wpcir=1, next state RUN.
REQ-048 mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pipe_hold high for 4 cycles, mem_timeout=0.
REQ-049 TMO_W=2, mem_ready held 0 -> mem_timeout set after the counter reaches 3 and stays set until clr.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects and FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] DEP_RF   = 2'b00;
  localparam logic [1:0] DEP_EALU = 2'b01;
  localparam logic [1:0] DEP_MALU = 2'b10;
  localparam logic [1:0] DEP_MMEM = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LDSTALL = 2'b01,
    ST_MEMWAIT = 2'b10
  } state_t;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one D-stage source operand; purely combinational.
module fwd_sel (
  input  logic [4:0] i_src,
  input  logic       i_ewreg,
  input  logic       i_em2reg,
  input  logic [4:0] i_ern,
  input  logic       i_mwreg,
  input  logic       i_mm2reg,
  input  logic [4:0] i_mrn,
  output logic [1:0] o_depen
);
  import pipe_hazard_ctrl_pkg::*;

  // A load in E has no data yet, so it falls through to the M-stage check.
  always_comb begin
    o_depen = DEP_RF;
    if (i_ewreg && !i_em2reg && (i_ern != 5'd0) && (i_ern == i_src)) begin
      o_depen = DEP_EALU;
    end else if (i_mwreg && (i_mrn != 5'd0) && (i_mrn == i_src)) begin
      o_depen = i_mm2reg ? DEP_MMEM : DEP_MALU;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/jump/memory-wait stalls, zero-cycle response.
// Optional saturating stall/flush counters are built when PIPE_HAZARD_STATS_EN is defined.
module pipe_hazard_ctrl #(
  parameter int TMO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             d_valid,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             d_use_rs,
  input  logic             d_use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             mwreg,
  input  logic             mm2reg,
  input  logic [4:0]       mrn,
  input  logic             e_jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       da_depen,
  output logic [1:0]       db_depen,
  output logic             wpcir,
  output logic             de_bubble,
  output logic             fd_flush,
  output logic             pipe_hold,
  output logic             mem_timeout
`ifdef PIPE_HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);
  import pipe_hazard_ctrl_pkg::*;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [TMO_W-1:0] r_wait_cnt;
  logic [TMO_W-1:0] w_cnt_nxt;
  logic             r_mem_timeout;
  logic             w_tmo_set;
  logic             w_load_use;

  fwd_sel u_fwd_rs (
    .i_src(d_rs), .i_ewreg(ewreg), .i_em2reg(em2reg), .i_ern(ern),
    .i_mwreg(mwreg), .i_mm2reg(mm2reg), .i_mrn(mrn), .o_depen(da_depen)
  );

  fwd_sel u_fwd_rt (
    .i_src(d_rt), .i_ewreg(ewreg), .i_em2reg(em2reg), .i_ern(ern),
    .i_mwreg(mwreg), .i_mm2reg(mm2reg), .i_mrn(mrn), .o_depen(db_depen)
  );

  assign w_load_use = d_valid && ewreg && em2reg && (ern != 5'd0) &&
                      ((d_use_rs && (ern == d_rs)) || (d_use_rt && (ern == d_rt)));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_cnt_nxt;
      r_mem_timeout <= r_mem_timeout | w_tmo_set;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_wait_cnt;
    w_tmo_set   = 1'b0;
    wpcir       = 1'b1;
    de_bubble   = 1'b0;
    fd_flush    = 1'b0;
    pipe_hold   = 1'b0;
    case (r_state)
      ST_MEMWAIT: begin
        pipe_hold = 1'b1;
        wpcir     = 1'b0;
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (&r_wait_cnt) begin
          w_tmo_set   = 1'b1;
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_wait_cnt + TMO_W'(1);
        end
      end
      // LDSTALL only marks the stall cycle; its response is identical to RUN.
      default: begin
        w_state_nxt = ST_RUN;
        if (mem_req && !mem_ready) begin
          pipe_hold   = 1'b1;
          wpcir       = 1'b0;
          w_state_nxt = ST_MEMWAIT;
        end else if (e_jump) begin
          fd_flush  = 1'b1;
          de_bubble = 1'b1;
        end else if (w_load_use) begin
          wpcir       = 1'b0;
          de_bubble   = 1'b1;
          w_state_nxt = ST_LDSTALL;
        end
      end
    endcase
  end

  assign mem_timeout = r_mem_timeout;

`ifdef PIPE_HAZARD_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!wpcir && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (fd_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with a 2-bit wait counter.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic       d_valid, d_use_rs, d_use_rt;
  logic [4:0] d_rs, d_rt, ern, mrn;
  logic       ewreg, em2reg, mwreg, mm2reg, e_jump, mem_req, mem_ready;
  logic [1:0] da_depen, db_depen;
  logic       wpcir, de_bubble, fd_flush, pipe_hold, mem_timeout;
`ifdef PIPE_HAZARD_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TMO_W(2), .CNT_W(16)) dut (
    .clk(clk), .clr(clr), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
    .d_use_rs(d_use_rs), .d_use_rt(d_use_rt), .ewreg(ewreg), .em2reg(em2reg),
    .ern(ern), .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .e_jump(e_jump),
    .mem_req(mem_req), .mem_ready(mem_ready), .da_depen(da_depen),
    .db_depen(db_depen), .wpcir(wpcir), .de_bubble(de_bubble),
    .fd_flush(fd_flush), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout)
`ifdef PIPE_HAZARD_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0] da;
    logic [1:0] db;
    logic       wpcir;
    logic       bub;
    logic       flush;
    logic       hold;
    logic       tmo;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;
  exp_t  mon_e, mon_g;
  string mon_nm;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    d_valid = 0; d_use_rs = 0; d_use_rt = 0; d_rs = 0; d_rt = 0;
    ewreg = 0; em2reg = 0; ern = 0; mwreg = 0; mm2reg = 0; mrn = 0;
    e_jump = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic expect_o(input string nm, input logic [1:0] da, input logic [1:0] db,
                          input logic w, input logic b, input logic f,
                          input logic h, input logic t);
    exp_t e;
    e.da = da; e.db = db; e.wpcir = w; e.bub = b; e.flush = f; e.hold = h; e.tmo = t;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: samples on the falling edge, half a cycle after stimulus settles.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_g  = {da_depen, db_depen, wpcir, de_bubble, fd_flush, pipe_hold, mem_timeout};
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL %s: got da=%b db=%b wpcir=%b bub=%b flush=%b hold=%b tmo=%b, expected da=%b db=%b wpcir=%b bub=%b flush=%b hold=%b tmo=%b",
                 mon_nm, mon_g.da, mon_g.db, mon_g.wpcir, mon_g.bub, mon_g.flush, mon_g.hold, mon_g.tmo,
                 mon_e.da, mon_e.db, mon_e.wpcir, mon_e.bub, mon_e.flush, mon_e.hold, mon_e.tmo);
      end
    end
  end

  initial begin
    clr = 1'b1;
    idle();
    repeat (2) @(posedge clk);

    cyc(); clr = 0; idle(); expect_o("reset_state", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Register zero never forwards or stalls
    cyc(); idle(); d_valid = 1; ewreg = 1; ern = 0; d_rs = 0; d_use_rs = 1;
    expect_o("r0_alu", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    cyc(); idle(); d_valid = 1; ewreg = 1; em2reg = 1; ern = 0; d_rs = 0; d_use_rs = 1;
    expect_o("r0_load", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Forwarding priority and encodings
    cyc(); idle(); d_valid = 1; ewreg = 1; ern = 3; mwreg = 1; mrn = 3;
    d_rs = 7; d_rt = 3; d_use_rs = 1; d_use_rt = 1;
    expect_o("e_over_m", 2'b00, 2'b01, 1, 0, 0, 0, 0);
    cyc(); idle(); d_valid = 1; mwreg = 1; mrn = 9; d_rs = 9; d_use_rs = 1;
    expect_o("m_alu_rs", 2'b10, 2'b00, 1, 0, 0, 0, 0);
    cyc(); idle(); d_valid = 1; mwreg = 1; mm2reg = 1; mrn = 12; d_rt = 12; d_use_rt = 1;
    expect_o("m_mem_rt", 2'b00, 2'b11, 1, 0, 0, 0, 0);
    cyc(); idle(); d_valid = 1; ewreg = 1; em2reg = 1; ern = 8; mwreg = 1; mrn = 8; d_rs = 8;
    expect_o("eload_falls_to_m", 2'b10, 2'b00, 1, 0, 0, 0, 0);
    cyc(); idle(); d_valid = 0; ewreg = 1; em2reg = 1; ern = 5; d_rs = 5; d_use_rs = 1;
    expect_o("lu_invalid_d", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Load-use on rs, then forwarded from M memory data
    cyc(); idle(); d_valid = 1; ewreg = 1; em2reg = 1; ern = 5; d_rs = 5; d_use_rs = 1;
    expect_o("lu_stall", 2'b00, 2'b00, 0, 1, 0, 0, 0);
    cyc(); idle(); d_valid = 1; mwreg = 1; mm2reg = 1; mrn = 5; d_rs = 5; d_use_rs = 1;
    expect_o("lu_after_fwd", 2'b11, 2'b00, 1, 0, 0, 0, 0);
    cyc(); idle(); expect_o("lu_back_run", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // A fresh load-use in the stall cycle stalls again
    cyc(); idle(); d_valid = 1; ewreg = 1; em2reg = 1; ern = 6; d_rt = 6; d_use_rt = 1;
    expect_o("lu_rt_stall", 2'b00, 2'b00, 0, 1, 0, 0, 0);
    cyc(); idle(); d_valid = 1; ewreg = 1; em2reg = 1; ern = 7; d_rs = 7; d_use_rs = 1;
    mwreg = 1; mm2reg = 1; mrn = 6; d_rt = 6; d_use_rt = 1;
    expect_o("lu_in_ldstall", 2'b00, 2'b11, 0, 1, 0, 0, 0);
    cyc(); idle(); expect_o("lu2_back_run", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Jump beats a coincident load-use
    cyc(); idle(); e_jump = 1; d_valid = 1; ewreg = 1; em2reg = 1; ern = 4; d_rs = 4; d_use_rs = 1;
    expect_o("jump_over_lu", 2'b00, 2'b00, 1, 1, 1, 0, 0);
    cyc(); idle(); expect_o("jump_next", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Memory wait of three cycles, ready on the fourth
    cyc(); idle(); mem_req = 1; mem_ready = 1;
    expect_o("mem_hit", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    cyc(); idle(); mem_req = 1; e_jump = 1;
    expect_o("mw_enter_over_jump", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    cyc(); idle(); mem_req = 1; e_jump = 1;
    expect_o("mw_ignore_jump", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    cyc(); idle(); mem_req = 1; d_valid = 1; ewreg = 1; em2reg = 1; ern = 5; d_rs = 5; d_use_rs = 1;
    expect_o("mw_ignore_lu", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    cyc(); idle(); mem_req = 1; mem_ready = 1;
    expect_o("mw_ready", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    cyc(); idle(); expect_o("mw_done", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Timeout with a 2-bit counter: flag appears after the all-ones cycle
    for (int i = 0; i < 5; i++) begin
      cyc(); idle(); mem_req = 1;
      expect_o("tmo_wait", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    end
    cyc(); idle(); mem_req = 1;
    expect_o("tmo_set_rewait", 2'b00, 2'b00, 0, 0, 0, 1, 1);
    cyc(); idle(); mem_ready = 1;
    expect_o("tmo_ready", 2'b00, 2'b00, 0, 0, 0, 1, 1);
    cyc(); idle(); expect_o("tmo_sticky1", 2'b00, 2'b00, 1, 0, 0, 0, 1);
    cyc(); idle(); expect_o("tmo_sticky2", 2'b00, 2'b00, 1, 0, 0, 0, 1);
    cyc(); idle(); clr = 1;
    cyc(); clr = 0; idle(); expect_o("tmo_cleared", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    // Reset while the counter sits at all-ones aborts without a timeout
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); mem_req = 1;
      expect_o("clr_wait", 2'b00, 2'b00, 0, 0, 0, 1, 0);
    end
    cyc(); idle(); mem_req = 1; clr = 1;
    cyc(); clr = 0; idle(); expect_o("clr_abort", 2'b00, 2'b00, 1, 0, 0, 0, 0);
    cyc(); idle(); expect_o("clr_abort_run", 2'b00, 2'b00, 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
